// File: rtl/motion_update_broadcaster_pkg.sv
// Shared definitions for the motion-update broadcast transmitter:
// FSM encoding, source timing constants and cell-ID packing.
package motion_update_broadcaster_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_NUM,
    S_WAIT_NUM,
    S_LATCH_NUM,
    S_STREAM,
    S_DRAIN,
    S_COOLDOWN
  } state_e;

  localparam int RD_LATENCY   = 2;
  localparam int COOLDOWN_LEN = 3;
  localparam int CID_MAX_W    = 16;

  // Packs {x, y, z} with each coordinate w bits wide, x in the top field.
  function automatic logic [3*CID_MAX_W-1:0] pack_cell(
    input logic [CID_MAX_W-1:0] x,
    input logic [CID_MAX_W-1:0] y,
    input logic [CID_MAX_W-1:0] z,
    input int unsigned          w
  );
    logic [3*CID_MAX_W-1:0] px, py, pz;
    px = {{(2*CID_MAX_W){1'b0}}, x};
    py = {{(2*CID_MAX_W){1'b0}}, y};
    pz = {{(2*CID_MAX_W){1'b0}}, z};
    return (px << (2*w)) | (py << w) | pz;
  endfunction

endpackage

// File: rtl/motion_update_broadcaster_if.sv
// Source-read and broadcast bus of the motion-update transmitter.
interface motion_update_broadcaster_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4
);
  logic                       start;
  logic [3*CELL_ID_WIDTH-1:0] rd_cell;
  logic [ADDR_WIDTH-1:0]      rd_address;
  logic                       rd_en;
  logic [3*DATA_WIDTH-1:0]    rd_data;
  logic [3*CELL_ID_WIDTH-1:0] rd_dst_cell;
  logic                       motion_update_enable;
  logic [3*DATA_WIDTH-1:0]    out_data;
  logic [3*CELL_ID_WIDTH-1:0] out_dst_cell;
  logic                       out_valid;
  logic                       busy;
  logic                       done;

  modport master (
    input  start, rd_data, rd_dst_cell,
    output rd_cell, rd_address, rd_en, motion_update_enable,
           out_data, out_dst_cell, out_valid, busy, done
  );

  modport slave (
    output start, rd_data, rd_dst_cell,
    input  rd_cell, rd_address, rd_en, motion_update_enable,
           out_data, out_dst_cell, out_valid, busy, done
  );
endinterface

// File: rtl/motion_update_broadcaster_cell_sweep_counter.sv
// 3-D cell counter, z fastest then y then x, each running 1..DIM and
// wrapping back to (1,1,1) after the last cell.
module cell_sweep_counter #(
  parameter int CELL_ID_WIDTH = 4,
  parameter int X_DIM         = 4,
  parameter int Y_DIM         = 4,
  parameter int Z_DIM         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  output logic [CELL_ID_WIDTH-1:0] x,
  output logic [CELL_ID_WIDTH-1:0] y,
  output logic [CELL_ID_WIDTH-1:0] z,
  output logic                     last
);
  localparam logic [CELL_ID_WIDTH-1:0] ONE = CELL_ID_WIDTH'(1);

  logic [CELL_ID_WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic x_last, y_last, z_last;

  assign x_last = (x_q == CELL_ID_WIDTH'(X_DIM));
  assign y_last = (y_q == CELL_ID_WIDTH'(Y_DIM));
  assign z_last = (z_q == CELL_ID_WIDTH'(Z_DIM));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    if (advance) begin
      if (!z_last) begin
        z_d = z_q + ONE;
      end else begin
        z_d = ONE;
        if (!y_last) begin
          y_d = y_q + ONE;
        end else begin
          y_d = ONE;
          x_d = x_last ? ONE : x_q + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= ONE;
      y_q <= ONE;
      z_q <= ONE;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign z    = z_q;
  assign last = x_last && y_last && z_last;
endmodule

// File: rtl/motion_update_broadcaster.sv
// Sweeps every cell, reads its count and records from the result buffer and
// broadcasts each record with its destination cell to the per-cell caches.
module motion_update_broadcaster
  import motion_update_broadcaster_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int X_DIM         = 4,
  parameter int Y_DIM         = 4,
  parameter int Z_DIM         = 4
) (
  input logic                       clk,
  input logic                       rst,
  motion_update_broadcaster_if.master bus
);
  localparam int CELL_W    = 3*CELL_ID_WIDTH;
  localparam int VEC_W     = 3*DATA_WIDTH;
  localparam int DRAIN_LEN = RD_LATENCY + 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   n_q, n_d, addr_q, addr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [RD_LATENCY:1]     vld_pipe_q, vld_pipe_d;
  logic                    out_valid_q, out_valid_d;
  logic [VEC_W-1:0]        out_data_q, out_data_d;
  logic [CELL_W-1:0]       out_dst_q, out_dst_d;

  logic                    rd_en, rd_tag, cell_adv, cell_last, mu_en, done;
  logic [ADDR_WIDTH-1:0]   rd_addr, n_sat;
  logic [CELL_ID_WIDTH-1:0] cx, cy, cz;
  logic [CELL_W-1:0]       cur_cell;
  logic                    pipe_empty;

  cell_sweep_counter #(
    .CELL_ID_WIDTH(CELL_ID_WIDTH), .X_DIM(X_DIM), .Y_DIM(Y_DIM), .Z_DIM(Z_DIM)
  ) u_cells (
    .clk(clk), .rst(rst), .advance(cell_adv),
    .x(cx), .y(cy), .z(cz), .last(cell_last)
  );

  assign cur_cell = CELL_W'(pack_cell(CID_MAX_W'(cx), CID_MAX_W'(cy),
                                      CID_MAX_W'(cz), CELL_ID_WIDTH));

  // Counts that do not fit in the address space clamp to the last address.
  assign n_sat = (|bus.rd_data[DATA_WIDTH-1:ADDR_WIDTH]) ? '1
                                                         : bus.rd_data[ADDR_WIDTH-1:0];
  assign pipe_empty = (vld_pipe_q == '0) && !out_valid_q;
  assign rd_tag     = (state_q == S_STREAM);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    cell_adv = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    mu_en    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = S_RD_NUM;
      S_RD_NUM: begin
        rd_en   = 1'b1;
        mu_en   = 1'b1;
        state_d = S_WAIT_NUM;
      end
      S_WAIT_NUM: begin
        mu_en   = 1'b1;
        state_d = S_LATCH_NUM;
      end
      S_LATCH_NUM: begin
        mu_en  = 1'b1;
        n_d    = n_sat;
        addr_d = ADDR_WIDTH'(1);
        cnt_d  = '0;
        if (n_sat == '0) begin
          cell_adv = 1'b1;
          state_d  = cell_last ? S_DRAIN : S_RD_NUM;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        mu_en   = 1'b1;
        rd_en   = 1'b1;
        rd_addr = addr_q;
        addr_d  = addr_q + 1'b1;
        if (addr_q == n_q) begin
          cell_adv = 1'b1;
          state_d  = cell_last ? S_DRAIN : S_RD_NUM;
        end
      end
      // Enable is held for the read latency plus the output register so the
      // last in-flight record is still covered; the exit cycle has it low.
      S_DRAIN: begin
        if (cnt_q != 2'(DRAIN_LEN)) begin
          mu_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end else if (pipe_empty) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == 2'(COOLDOWN_LEN-1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vld_pipe_d  = {vld_pipe_q[RD_LATENCY-1:1], rd_tag};
    out_valid_d = vld_pipe_q[RD_LATENCY];
    out_data_d  = out_valid_d ? bus.rd_data     : '0;
    out_dst_d   = out_valid_d ? bus.rd_dst_cell : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      vld_pipe_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_dst_q   <= out_dst_d;
    end
  end

  assign bus.rd_en                = rd_en;
  assign bus.rd_address           = rd_addr;
  assign bus.rd_cell              = rd_en ? cur_cell : '0;
  assign bus.motion_update_enable = mu_en;
  assign bus.done                 = done;
  assign bus.busy                 = (state_q != S_IDLE);
  assign bus.out_valid            = out_valid_q;
  assign bus.out_data             = out_data_q;
  assign bus.out_dst_cell         = out_dst_q;
endmodule

// File: doc/motion_update_broadcaster.md
# motion_update_broadcaster

- Transmitting end of the motion-update broadcast bus.
- Sweeps every cell in a fixed order and, for each cell, reads the particle count and then each updated particle record from the upstream motion-update result buffer.
- Broadcasts each record with its destination cell ID to all per-cell double-buffered caches (position/velocity).
- Holds `motion_update_enable` high for the whole sweep, then guarantees the low gap the caches need to commit the particle count and swap buffers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of one vector component; records are `{z, y, x}`.
- `ADDR_WIDTH`, 8: per-cell address width; address 0 holds the particle count.
- `CELL_ID_WIDTH`, 4: width of one cell coordinate.
- `X_DIM`, 4: number of cells along x; cell IDs run 1..X_DIM.
- `Y_DIM`, 4: number of cells along y; cell IDs run 1..Y_DIM.
- `Z_DIM`, 4: number of cells along z; cell IDs run 1..Z_DIM.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a sweep; ignored unless idle.
- `rd_cell` out 3*CELL_ID_WIDTH: source cell select `{x, y, z}`.
- `rd_address` out ADDR_WIDTH: source read address.
- `rd_en` out 1: source read enable.
- `rd_data` in 3*DATA_WIDTH: source readout; low ADDR_WIDTH bits carry the count when address 0 is read.
- `rd_dst_cell` in 3*CELL_ID_WIDTH: destination cell of the record read; same timing as `rd_data`.
- `motion_update_enable` out 1: high for the whole broadcast.
- `out_data` out 3*DATA_WIDTH: broadcast record.
- `out_dst_cell` out 3*CELL_ID_WIDTH: broadcast destination `{x, y, z}`.
- `out_valid` out 1: `out_data` and `out_dst_cell` are valid this cycle.
- `busy` out 1: high from the cycle after `start` is accepted until the return to IDLE.
- `done` out 1: one-cycle pulse when `motion_update_enable` falls.

## Operation
- **Reset:** all outputs are 0; FSM is IDLE; cell counters are (1,1,1); the pipeline is empty.
- **Cell order:** z fastest, then y, then x, starting at (1,1,1) and ending at (X_DIM,Y_DIM,Z_DIM).
- **FSM states:**
  - IDLE: on `start`, go to RD_NUM.
  - RD_NUM: issue a read of address 0 for the current cell, then go to WAIT_NUM.
  - WAIT_NUM: wait one cycle, then go to LATCH_NUM.
  - LATCH_NUM: latch count N = `rd_data[ADDR_WIDTH-1:0]`.
    - If N = 0 and this is not the last cell: advance the cell and go to RD_NUM.
    - If N = 0 and this is the last cell: go to DRAIN.
    - Otherwise: go to STREAM.
  - STREAM: issue reads of addresses 1..N on consecutive cycles. After address N, advance the cell and go to RD_NUM, or go to DRAIN if this is the last cell.
  - DRAIN: wait until the broadcast pipeline is empty, then go to COOLDOWN.
  - COOLDOWN: hold for 3 cycles, then go to IDLE.
- **Count handling:** N saturates at 2^ADDR_WIDTH−1. The count is never broadcast.
- **Broadcast pipeline:** a particle-read tag travels down a 2-stage valid shift register. When it reaches the stage that coincides with `rd_data`, `rd_data` and `rd_dst_cell` are registered into `out_data` and `out_dst_cell`, and `out_valid` is driven high.
- **Idle output values:** whenever `out_valid` is 0, `out_data` and `out_dst_cell` are 0.
- **Enable window:** `motion_update_enable` rises in the RD_NUM cycle of the first cell. It stays high up to and including the cycle of the last `out_valid`, and falls the next cycle; `done` pulses in that falling cycle.
- **Gap to next sweep:** enable stays low for at least 4 cycles (DRAIN exit plus COOLDOWN) before any new sweep. This lets receivers complete their count-write and buffer-swap states.
- **Start handling:**
  - `start` while `busy` is dropped, not queued.
  - `start` on the same cycle as the return to IDLE is also ignored; it is accepted only while in IDLE.
- **Reset mid-sweep:** all outputs drop to 0 immediately and nothing resumes. Receiving caches share `rst`.

## Timing
- Source read latency is fixed at 2: an address issued in cycle t returns data in cycle t+2.
- Particle read at t produces its broadcast at t+3.
- Per cell with N particles:
  - address 0 at T;
  - count at T+2;
  - particle reads at T+3..T+2+N;
  - next cell's address 0 at T+3+N.
- Cell period is N+3 cycles; an empty cell takes 3 cycles.
- Full sweep latency is the sum over cells of (N_i+3), plus 3 for pipeline drain.
- Broadcasts of adjacent cells follow each other with exactly 3 empty cycles between them.

## Structure
- A shared package holds:
  - the FSM state encoding;
  - the fixed source read latency, 2;
  - the cooldown length, 3;
  - cell-ID packing helpers.
- One sub-module, `cell_sweep_counter`: a 3-D wrap counter over (x,y,z) with `advance` and `last` outputs.

## Test plan
- 2×2×2 grid, all cells holding N=1: the 8 broadcasts appear 4 cycles apart, in z-fastest order; enable stays high 35 cycles; `done` pulses once.
- Cell (1,1,2) holds 3 records with `rd_dst_cell` = (2,1,1): three consecutive `out_valid` cycles carry data identical to the source, with the right destination.
- All cells empty: no `out_valid`; enable stays high 3·cells+3 cycles; `busy` then drops 4 cycles after `done`.
- Count word = 0x1FF with ADDR_WIDTH=8: reads stop at address 255.
- `start` pulsed mid-sweep and in COOLDOWN: ignored; exactly one `done`.
- `rst` asserted mid-STREAM: all outputs 0 within the same cycle; a new `start` after release sweeps from (1,1,1).
